// File: rtl/cpu7_dtcm_pkg.sv
// -----------------------------------------------------------------------------
// cpu7_dtcm_pkg
//   Definitions shared by the data TCM and, later, the data cache responder:
//   exception codes, access-size encodings, the layout of one response entry,
//   and the alignment rule applied to every data request.
// -----------------------------------------------------------------------------
package cpu7_dtcm_pkg;

    // Exception codes reported on data_exccode.
    localparam logic [5:0] EXC_NONE = 6'h00;
    localparam logic [5:0] EXC_ADE  = 6'h08;   // address outside the memory region
    localparam logic [5:0] EXC_ALE  = 6'h09;   // misaligned access

    // data_size encodings. The reserved code behaves exactly like a word.
    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_RSVD = 2'd3
    } mem_size_e;

    // One response as presented to the pipeline.
    typedef struct packed {
        logic [31:0] rdata;     // full aligned word, zero for stores/exceptions
        logic        exc;       // response is an exception
        logic [5:0]  exccode;   // valid when exc
        logic [31:0] badvaddr;  // faulting address, valid when exc
    } dtcm_resp_t;

    // True when the access is not naturally aligned for its size.
    function automatic logic misaligned(input logic [1:0] size,
                                        input logic [1:0] addr_lo);
        logic bad;
        case (mem_size_e'(size))
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = addr_lo[0];
            default:   bad = (addr_lo != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/cpu7_dtcm_ram.sv
// -----------------------------------------------------------------------------
// cpu7_dtcm_ram
//   Single-port byte-writable SRAM, one registered read port, write-first.
//   Behavioural model meant to be replaced by a vendor macro of the same shape.
//
//   Ports:
//     clk    in   clock
//     en     in   access enable (read, or write when we=1)
//     we     in   write enable
//     be     in   per-byte write enables
//     addr   in   word address
//     wdata  in   write data
//     rdata  out  registered read data; on a write returns the merged word
// -----------------------------------------------------------------------------
module cpu7_dtcm_ram #(
    parameter int ADDR_W = 12,
    parameter int LANES  = 4
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic                 we,
    input  logic [LANES-1:0]     be,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [LANES*8-1:0]   wdata,
    output logic [LANES*8-1:0]   rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    // One independent byte-wide array per lane keeps byte writes simple for
    // inference and gives each lane its own write-first output register.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] mem [0:DEPTH-1];
            logic [7:0] rdata_reg;

            always_ff @(posedge clk) begin
                if (en) begin
                    if (we && be[gi]) begin
                        mem[addr]  <= wdata[gi*8 +: 8];
                        rdata_reg  <= wdata[gi*8 +: 8];
                    end else begin
                        rdata_reg  <= mem[addr];
                    end
                end
            end

            assign rdata[gi*8 +: 8] = rdata_reg;
        end
    endgenerate

endmodule

// File: rtl/cpu7_dtcm.sv
// -----------------------------------------------------------------------------
// cpu7_dtcm
//   Data tightly-coupled memory answering the pipeline data-request interface.
//   Loads and stores go straight to on-chip SRAM; out-of-region and misaligned
//   accesses return precise exceptions. Up to two responses can be pending
//   (an SRAM read in flight plus buffered entries), delivered in order.
//
//   Ports:
//     clk, reset        clock, asynchronous active-high reset
//     data_req          request valid
//     data_addr         byte address
//     data_wr           1=store, 0=load
//     data_size         0=byte 1=half 2=word 3=word
//     data_wstrb        lane-aligned byte enables for stores
//     data_wdata        lane-aligned store data
//     data_cancel       flush all accepted, undelivered responses
//     data_recv         pipeline consumes the head response
//     data_addr_ok      request accepted this cycle
//     data_data_ok      head response valid
//     data_rdata        head read data (full aligned word)
//     data_exception    head response is an exception
//     data_exccode      head exception code
//     data_badvaddr     head faulting address
//     data_req_empty    nothing in flight and nothing buffered
// -----------------------------------------------------------------------------
module cpu7_dtcm
    import cpu7_dtcm_pkg::*;
#(
    parameter int               GRLEN      = 32,
    parameter int               DEPTH_LOG2 = 12,
    parameter logic [GRLEN-1:0] BASE_ADDR  = 32'h1c000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_req,
    input  logic [GRLEN-1:0] data_addr,
    input  logic             data_wr,
    input  logic [1:0]       data_size,
    input  logic [3:0]       data_wstrb,
    input  logic [GRLEN-1:0] data_wdata,
    input  logic             data_cancel,
    input  logic             data_recv,
    output logic             data_addr_ok,
    output logic             data_data_ok,
    output logic [GRLEN-1:0] data_rdata,
    output logic             data_exception,
    output logic [5:0]       data_exccode,
    output logic [GRLEN-1:0] data_badvaddr,
    output logic             data_req_empty
);

    localparam int TAG_LSB = DEPTH_LOG2 + 2;
    localparam logic [GRLEN-1:TAG_LSB] BASE_TAG = BASE_ADDR[GRLEN-1:TAG_LSB];

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    // reset_q_reg holds off acceptance for the first cycle after reset release
    // so the very first accept never races the reset edge.
    logic        reset_q_reg;

    // The in-flight stage holds the request accepted on the previous edge.
    // For a load its data is the SRAM output of this cycle.
    logic              infl_valid_reg;
    logic              infl_rd_reg;
    logic              infl_exc_reg;
    logic [5:0]        infl_exccode_reg;
    logic [GRLEN-1:0]  infl_badvaddr_reg;

    // Two-entry response FIFO behind the in-flight stage.
    dtcm_resp_t  fifo_mem [0:1];
    logic        rd_ptr_reg;
    logic        wr_ptr_reg;
    logic [1:0]  buf_cnt_reg;

    // -------------------------------------------------------------------------
    // Request checks
    // -------------------------------------------------------------------------
    logic        req_ale;
    logic        req_ade;
    logic        req_fault;
    logic [5:0]  req_exccode;

    always_comb begin
        req_ale     = misaligned(data_size, data_addr[1:0]);
        req_ade     = (data_addr[GRLEN-1:TAG_LSB] != BASE_TAG);
        req_fault   = req_ale | req_ade;
        // Alignment takes priority when both checks trip.
        req_exccode = req_ale ? EXC_ALE : (req_ade ? EXC_ADE : EXC_NONE);
    end

    // -------------------------------------------------------------------------
    // SRAM
    // -------------------------------------------------------------------------
    logic             acc;
    logic             ram_en;
    logic [GRLEN-1:0] ram_rdata;

    // Faulting requests never touch the array; stores write on the accept edge.
    assign ram_en = acc & ~req_fault;

    cpu7_dtcm_ram #(
        .ADDR_W (DEPTH_LOG2),
        .LANES  (4)
    ) u_ram (
        .clk    (clk),
        .en     (ram_en),
        .we     (data_wr),
        .be     (data_wstrb),
        .addr   (data_addr[TAG_LSB-1:2]),
        .wdata  (data_wdata),
        .rdata  (ram_rdata)
    );

    // -------------------------------------------------------------------------
    // Occupancy, head selection and handshakes
    // -------------------------------------------------------------------------
    logic [1:0]  occ;
    dtcm_resp_t  infl_resp;
    dtcm_resp_t  head_resp;
    logic        buf_empty;
    logic        pop;
    logic        pop_buf;
    logic        push;

    assign occ       = buf_cnt_reg + {1'b0, infl_valid_reg};
    assign buf_empty = (buf_cnt_reg == 2'd0);

    // Resolved in-flight response; only loads carry SRAM data.
    always_comb begin
        infl_resp          = '0;
        infl_resp.rdata    = infl_rd_reg ? ram_rdata : '0;
        infl_resp.exc      = infl_exc_reg;
        infl_resp.exccode  = infl_exccode_reg;
        infl_resp.badvaddr = infl_badvaddr_reg;
    end

    // Buffered entries are older than the in-flight one, so they go first.
    // With an empty buffer the in-flight entry is presented directly, which is
    // what gives the one-cycle response latency.
    always_comb begin
        head_resp = '0;
        if (!buf_empty) begin
            head_resp = fifo_mem[rd_ptr_reg];
        end else if (infl_valid_reg) begin
            head_resp = infl_resp;
        end
    end

    assign data_data_ok = (occ != 2'd0);
    assign pop          = data_data_ok & data_recv;
    assign pop_buf      = pop & ~buf_empty;
    // The in-flight entry moves into the buffer unless it is consumed directly.
    assign push         = infl_valid_reg & ~(pop & buf_empty);

    // A slot frees up in the same cycle as a pop, so a full pipe can still
    // accept while the head is being consumed.
    assign data_addr_ok = ~reset_q_reg & ~data_cancel &
                          ((occ < 2'd2) | ((occ == 2'd2) & pop));
    assign acc          = data_req & data_addr_ok;

    assign data_rdata     = head_resp.rdata;
    assign data_exception = head_resp.exc;
    assign data_exccode   = head_resp.exccode;
    assign data_badvaddr  = head_resp.badvaddr;
    assign data_req_empty = (occ == 2'd0);

    // -------------------------------------------------------------------------
    // Sequential control
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reset_q_reg       <= 1'b1;
            infl_valid_reg    <= 1'b0;
            infl_rd_reg       <= 1'b0;
            infl_exc_reg      <= 1'b0;
            infl_exccode_reg  <= EXC_NONE;
            infl_badvaddr_reg <= '0;
            rd_ptr_reg        <= 1'b0;
            wr_ptr_reg        <= 1'b0;
            buf_cnt_reg       <= 2'd0;
        end else begin
            reset_q_reg <= 1'b0;
            if (data_cancel) begin
                // Drop everything pending; stores already in the SRAM stay.
                infl_valid_reg <= 1'b0;
                infl_rd_reg    <= 1'b0;
                rd_ptr_reg     <= 1'b0;
                wr_ptr_reg     <= 1'b0;
                buf_cnt_reg    <= 2'd0;
            end else begin
                if (push) begin
                    wr_ptr_reg <= ~wr_ptr_reg;
                end
                if (pop_buf) begin
                    rd_ptr_reg <= ~rd_ptr_reg;
                end
                buf_cnt_reg    <= buf_cnt_reg + {1'b0, push} - {1'b0, pop_buf};
                infl_valid_reg <= acc;
                if (acc) begin
                    infl_rd_reg       <= ~data_wr & ~req_fault;
                    infl_exc_reg      <= req_fault;
                    infl_exccode_reg  <= req_exccode;
                    infl_badvaddr_reg <= req_fault ? data_addr : '0;
                end
            end
        end
    end

    // FIFO storage needs no reset: entries are only observed once counted.
    always_ff @(posedge clk) begin
        if (push && !data_cancel) begin
            fifo_mem[wr_ptr_reg] <= infl_resp;
        end
    end

endmodule
